// File: rtl/booth_seq_5_if.sv
// Step-stage bus between the Booth sequencer and the radix-4 Booth step stage.
// The master side (sequencer) issues one window per request and the slave side
// (step stage) answers with the updated partial product.
interface booth_seq_5_if #(
  parameter int A_W = 12,
  parameter int P_W = 24
);
  logic           step_en;
  logic [2:0]     step_win;
  logic [A_W-1:0] step_mcand;
  logic [P_W-1:0] step_pre;
  logic           step_rdy;
  logic [P_W-1:0] step_next;

  modport master (
    output step_en, step_win, step_mcand, step_pre,
    input  step_rdy, step_next
  );

  modport slave (
    input  step_en, step_win, step_mcand, step_pre,
    output step_rdy, step_next
  );
endinterface

// File: rtl/booth_seq_5.sv
// Radix-4 Booth sequencer for the fft_5 butterfly multiplier path.
// Latches the operands, walks the Booth windows MSB-first through the external
// step stage (Horner form: acc = 4*acc + d*b), and returns the product with a
// one-cycle done pulse. All outputs are registered.
module booth_seq_5 #(
  parameter int A_W = 12,
  parameter int P_W = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [A_W-1:0] mul_a,
  input  logic [A_W-1:0] mul_b,
  output logic           busy,
  output logic           done,
  output logic [P_W-1:0] product,
  output logic           mcand_ovf,
  booth_seq_5_if.master  step
);
  localparam int NUM_WIN = A_W / 2;
  localparam int IDX_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WIN - 1);
  localparam logic [A_W-1:0]   MIN_NEG  = {1'b1, {(A_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [A_W-1:0] a_q, a_d;
  logic [A_W-1:0] b_q, b_d;
  logic [P_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic           ovf_q, ovf_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [P_W-1:0] product_q, product_d;
  logic           mcand_ovf_q, mcand_ovf_d;
  logic           en_q, en_d;
  logic [2:0]     win_q, win_d;
  logic [A_W-1:0] mcand_q, mcand_d;
  logic [P_W-1:0] pre_q, pre_d;

  // Window i is {a[2i+1], a[2i], a[2i-1]} with a[-1] = 0; appending a zero LSB
  // turns that into bits [2i+2:2i] of the extended operand.
  function automatic logic [2:0] booth_window(input logic [A_W-1:0] a,
                                              input logic [IDX_W-1:0] i);
    logic [A_W:0] ext;
    ext = {a, 1'b0} >> {i, 1'b0};
    return ext[2:0];
  endfunction

  // Negating digits (-2b, -b) of the most negative multiplicand wrap in the
  // step stage's A_W-bit negation, so the product becomes invalid.
  function automatic logic wraps(input logic [A_W-1:0] b, input logic [2:0] w);
    return (b == MIN_NEG) && ((w == 3'b100) || (w == 3'b101) || (w == 3'b110));
  endfunction

  // Next-state logic: the step-stage request is prepared on entry to ISSUE so
  // it appears on registered outputs during the ISSUE cycle.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    ovf_d       = ovf_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    product_d   = product_q;
    mcand_ovf_d = mcand_ovf_q;
    en_d        = 1'b0;
    win_d       = 3'b000;
    mcand_d     = '0;
    pre_d       = '0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          a_d     = mul_a;
          b_d     = mul_b;
          acc_d   = '0;
          idx_d   = LAST_IDX;
          win_d   = booth_window(mul_a, LAST_IDX);
          ovf_d   = wraps(mul_b, booth_window(mul_a, LAST_IDX));
          en_d    = 1'b1;
          mcand_d = mul_b;
          pre_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy_d  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy_d = 1'b1;
        if (step.step_rdy) begin
          acc_d = step.step_next;
          if (idx_q == '0) begin
            product_d   = step.step_next;
            mcand_ovf_d = ovf_q;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end else begin
            idx_d   = idx_q - 1'b1;
            win_d   = booth_window(a_q, idx_q - 1'b1);
            ovf_d   = ovf_q | wraps(b_q, booth_window(a_q, idx_q - 1'b1));
            en_d    = 1'b1;
            mcand_d = b_q;
            pre_d   = step.step_next << 2;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      product_q   <= '0;
      mcand_ovf_q <= 1'b0;
      en_q        <= 1'b0;
      win_q       <= 3'b000;
      mcand_q     <= '0;
      pre_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      product_q   <= product_d;
      mcand_ovf_q <= mcand_ovf_d;
      en_q        <= en_d;
      win_q       <= win_d;
      mcand_q     <= mcand_d;
      pre_q       <= pre_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign product         = product_q;
  assign mcand_ovf       = mcand_ovf_q;
  assign step.step_en    = en_q;
  assign step.step_win   = win_q;
  assign step.step_mcand = mcand_q;
  assign step.step_pre   = pre_q;
endmodule

// File: tb/tb_booth_seq_5.sv
// Directed testbench for booth_seq_5 with a behavioural Booth step stage whose
// response delay is adjustable.
module tb_booth_seq_5;
  localparam int A_W = 12;
  localparam int P_W = 24;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [A_W-1:0] mul_a;
  logic [A_W-1:0] mul_b;
  logic           busy;
  logic           done;
  logic [P_W-1:0] product;
  logic           mcand_ovf;

  int errors = 0;
  int checks = 0;
  int rdy_delay = 0;

  logic           pending;
  int             cnt;
  logic [P_W-1:0] pend_val;

  booth_seq_5_if #(.A_W(A_W), .P_W(P_W)) step_if ();

  booth_seq_5 #(.A_W(A_W), .P_W(P_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .mcand_ovf (mcand_ovf),
    .step      (step_if)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // One Booth step: pre + d*b, with -b formed by a 12-bit negation.
  function automatic logic [P_W-1:0] step_calc(input logic [2:0] w,
                                               input logic [A_W-1:0] b,
                                               input logic [P_W-1:0] pre);
    logic [A_W-1:0] nb;
    logic [P_W-1:0] bx;
    logic [P_W-1:0] nbx;
    nb  = -b;
    bx  = {{(P_W-A_W){b[A_W-1]}}, b};
    nbx = {{(P_W-A_W){nb[A_W-1]}}, nb};
    case (w)
      3'b001, 3'b010: return pre + bx;
      3'b011:         return pre + (bx << 1);
      3'b100:         return pre + (nbx << 1);
      3'b101, 3'b110: return pre + nbx;
      default:        return pre;
    endcase
  endfunction

  // Step stage model: answers each request after rdy_delay extra cycles.
  always @(posedge clk) begin
    if (rst) begin
      step_if.step_rdy  <= 1'b0;
      step_if.step_next <= '0;
      pending           <= 1'b0;
      cnt               <= 0;
      pend_val          <= '0;
    end else if (step_if.step_en) begin
      if (rdy_delay == 0) begin
        step_if.step_rdy  <= 1'b1;
        step_if.step_next <= step_calc(step_if.step_win, step_if.step_mcand, step_if.step_pre);
        pending           <= 1'b0;
      end else begin
        step_if.step_rdy  <= 1'b0;
        step_if.step_next <= '0;
        pending           <= 1'b1;
        cnt               <= rdy_delay;
        pend_val          <= step_calc(step_if.step_win, step_if.step_mcand, step_if.step_pre);
      end
    end else if (pending) begin
      if (cnt > 1) begin
        cnt               <= cnt - 1;
        step_if.step_rdy  <= 1'b0;
        step_if.step_next <= '0;
      end else begin
        step_if.step_rdy  <= 1'b1;
        step_if.step_next <= pend_val;
        pending           <= 1'b0;
      end
    end else begin
      step_if.step_rdy  <= 1'b0;
      step_if.step_next <= '0;
    end
  end

  // Start one multiply and follow it to done; cyc stays -1 if done never comes.
  // A stray start with other operands is pulsed during cycle poke_cyc.
  task automatic run_op(input logic [A_W-1:0] a, input logic [A_W-1:0] b,
                        input int poke_cyc, output int cyc,
                        output logic [31:0] en_trace, output logic [17:0] wins);
    int nw;
    cyc = -1;
    en_trace = '0;
    wins = '0;
    nw = 0;
    @(negedge clk);
    start = 1'b1;
    mul_a = a;
    mul_b = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == poke_cyc) begin
        start = 1'b1;
        mul_a = 12'h7FF;
        mul_b = 12'h7FF;
      end else begin
        start = 1'b0;
      end
      if (step_if.step_en) begin
        if (c < 32) en_trace[c] = 1'b1;
        if (nw < 6) begin
          wins = {wins[14:0], step_if.step_win};
          nw++;
        end
      end
      if (done) begin
        cyc = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    mul_a = '0;
    mul_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, mcand_ovf} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got busy/done/ovf=%b expected 000", {busy, done, mcand_ovf});
    end
    checks++;
    if (product !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_product: got %h expected 000000", product);
    end
    checks++;
    if ({step_if.step_en, step_if.step_win, step_if.step_mcand, step_if.step_pre} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_step_bus: got en=%b win=%b mcand=%h pre=%h expected all 0",
               step_if.step_en, step_if.step_win, step_if.step_mcand, step_if.step_pre);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    logic [31:0] en_trace;
    logic [17:0] wins;
    run_op(12'd3, 12'd5, 4, cyc, en_trace, wins);
    checks++;
    if (cyc !== 13) begin
      errors++;
      $display("[TB] FAIL basic_latency: got done cycle %0d expected 13", cyc);
    end
    checks++;
    if (product !== 24'h00000F) begin
      errors++;
      $display("[TB] FAIL basic_product: got %h expected 00000f", product);
    end
    checks++;
    if (mcand_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_ovf: got %b expected 0", mcand_ovf);
    end
    checks++;
    if (en_trace !== 32'h0000_0AAA) begin
      errors++;
      $display("[TB] FAIL basic_step_en_cycles: got %h expected 00000aaa", en_trace);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({done, product} !== {1'b0, 24'h00000F}) begin
      errors++;
      $display("[TB] FAIL basic_hold: got done=%b product=%h expected done=0 product=00000f", done, product);
    end
  endtask

  task automatic test_neg_one();
    int cyc;
    logic [31:0] en_trace;
    logic [17:0] wins;
    run_op(12'hFFF, 12'd7, 0, cyc, en_trace, wins);
    checks++;
    if (product !== 24'hFFFFF9) begin
      errors++;
      $display("[TB] FAIL neg_one_product: got %h expected fffff9", product);
    end
    checks++;
    if (wins !== 18'b111_111_111_111_111_110) begin
      errors++;
      $display("[TB] FAIL neg_one_windows: got %b expected 111111111111111110", wins);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int ndone;
    logic [31:0] en_trace;
    logic [17:0] wins;
    run_op(12'h800, 12'h801, 0, cyc, en_trace, wins);
    checks++;
    if ({cyc == 13, product} !== {1'b1, 24'h3FF800}) begin
      errors++;
      $display("[TB] FAIL b2b_first: got cycle=%0d product=%h expected cycle=13 product=3ff800", cyc, product);
    end
    start = 1'b1;
    mul_a = 12'h7FF;
    mul_b = 12'h7FF;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_done_cycle_start_ignored: got busy=%b expected 0", busy);
    end
    @(posedge clk);
    #1 start = 1'b0;
    cyc = -1;
    ndone = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (cyc < 0) cyc = c;
      end
      if (c >= 20 && cyc > 0) break;
    end
    checks++;
    if ({cyc == 13, ndone == 1} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL b2b_second_latency: got cycle=%0d dones=%0d expected cycle=13 dones=1", cyc, ndone);
    end
    checks++;
    if (product !== 24'h3FF001) begin
      errors++;
      $display("[TB] FAIL b2b_second_product: got %h expected 3ff001", product);
    end
  endtask

  task automatic test_ovf();
    int cyc;
    logic [31:0] en_trace;
    logic [17:0] wins;
    run_op(12'd1, 12'h800, 0, cyc, en_trace, wins);
    checks++;
    if ({product, mcand_ovf} !== {24'hFFF800, 1'b0}) begin
      errors++;
      $display("[TB] FAIL ovf_positive_digits: got product=%h ovf=%b expected fff800 ovf=0", product, mcand_ovf);
    end
    run_op(12'hFFF, 12'h800, 0, cyc, en_trace, wins);
    checks++;
    if ({done, mcand_ovf} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL ovf_negative_digit: got done=%b ovf=%b expected done=1 ovf=1", done, mcand_ovf);
    end
  endtask

  task automatic test_slow_step();
    int cyc;
    logic [31:0] en_trace;
    logic [17:0] wins;
    rdy_delay = 3;
    run_op(12'h123, 12'h0AB, 0, cyc, en_trace, wins);
    rdy_delay = 0;
    checks++;
    if (cyc !== 31) begin
      errors++;
      $display("[TB] FAIL slow_latency: got done cycle %0d expected 31", cyc);
    end
    checks++;
    if (product !== 24'h00C261) begin
      errors++;
      $display("[TB] FAIL slow_product: got %h expected 00c261", product);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int ndone;
    logic [31:0] en_trace;
    logic [17:0] wins;
    @(negedge clk);
    start = 1'b1;
    mul_a = 12'h123;
    mul_b = 12'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if ({busy, step_if.step_en} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL mid_reset_in_wait: got busy/step_en=%b expected 10", {busy, step_if.step_en});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, product} !== {1'b0, 1'b0, 24'h0}) begin
      errors++;
      $display("[TB] FAIL mid_reset_clear: got busy=%b done=%b product=%h expected 0 0 000000", busy, done, product);
    end
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("[TB] FAIL mid_reset_no_done: got %0d dones expected 0", ndone);
    end
    run_op(12'd2, 12'hFFD, 0, cyc, en_trace, wins);
    checks++;
    if ({cyc == 13, product} !== {1'b1, 24'hFFFFFA}) begin
      errors++;
      $display("[TB] FAIL mid_reset_restart: got cycle=%0d product=%h expected cycle=13 product=fffffa", cyc, product);
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_basic();
    test_neg_one();
    test_back_to_back();
    test_ovf();
    test_slow_step();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
